// File: rtl/mux5_rr_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the 5-way round-robin
// arbiter that drives the 5:1 mux select.
package mux5_pkg;

    localparam int N_REQ = 5;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_IDLE_DEFAULT = 3'd0;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux5_rr_arbiter_if.sv
// Requester/arbiter bundle: request vector in, grant/select/status out.
interface mux5_rr_arbiter_if;
    import mux5_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             owner_timeout;

    modport master (
        output req,
        input  grant,
        input  sel,
        input  busy,
        input  owner_timeout
    );

    modport slave (
        input  req,
        output grant,
        output sel,
        output busy,
        output owner_timeout
    );

endinterface

// File: rtl/mux5_rr_arbiter_rr_pick5.sv
// Combinational round-robin picker: first candidate after 'last', wrapping
// 4->0, ignoring requesters masked by 'exclude'.
module rr_pick5
    import mux5_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    input  logic [N_REQ-1:0] exclude,
    output logic [SEL_W-1:0] pick,
    output logic             found
);

    logic [N_REQ-1:0] cand;
    int               idx;

    always_comb begin
        cand  = req & ~exclude;
        pick  = SEL_IDLE_DEFAULT;
        found = 1'b0;
        idx   = 0;
        // Scan last+1 .. last+5 so 'last' itself is visited only as the final choice.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter with bounded tenure; owns the registered mux select.
//   state | meaning
//   IDLE  | no grant outstanding, sel keeps its last value
//   OWN   | one requester holds the grant, hold_cnt counts its tenure
module mux5_rr_arbiter
    import mux5_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux5_rr_arbiter_if.slave  bus
);

    state_t           state_q, state_n;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic             busy_q, busy_n;
    logic             to_q, to_n;
    logic [SEL_W-1:0] last_q, last_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic [N_REQ-1:0] exclude;
    logic [SEL_W-1:0] pick;
    logic             found;
    logic             expire;

    // While owning, the current owner is masked so found means "someone else waits".
    assign exclude = (state_q == OWN) ? onehot(last_q) : '0;
    assign expire  = (cnt_q == CNT_W'(HOLD_MAX - 1));

    rr_pick5 u_pick (
        .req     (bus.req),
        .last    (last_q),
        .exclude (exclude),
        .pick    (pick),
        .found   (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= SEL_IDLE_DEFAULT;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            last_q  <= SEL_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            sel_q   <= sel_n;
            busy_q  <= busy_n;
            to_q    <= to_n;
            last_q  <= last_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        sel_n   = sel_q;
        busy_n  = busy_q;
        to_n    = 1'b0;
        last_n  = last_q;
        cnt_n   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_n = OWN;
                    grant_n = onehot(pick);
                    sel_n   = pick;
                    busy_n  = 1'b1;
                    last_n  = pick;
                    cnt_n   = '0;
                end
            end
            OWN: begin
                if (!bus.req[last_q]) begin
                    // Release takes precedence over expiry, so no timeout pulse here.
                    if (found) begin
                        grant_n = onehot(pick);
                        sel_n   = pick;
                        last_n  = pick;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        busy_n  = 1'b0;
                    end
                    cnt_n = '0;
                end else if (expire && found) begin
                    grant_n = onehot(pick);
                    sel_n   = pick;
                    last_n  = pick;
                    to_n    = 1'b1;
                    cnt_n   = '0;
                end else if (expire) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.grant         = grant_q;
    assign bus.sel           = sel_q;
    assign bus.busy          = busy_q;
    assign bus.owner_timeout = to_q;

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Self-checking bench for mux5_rr_arbiter (HOLD_MAX=4 main instance,
// HOLD_MAX=1 companion for the rotate-every-cycle boundary).
module tb_mux5_rr_arbiter;

    typedef struct packed {
        logic [4:0] req;
        logic [4:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic       to;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t exp_q[$];
    vec_t tbl_a[6];
    vec_t tbl_d[5];

    always #5 clk = ~clk;

    mux5_rr_arbiter_if bus ();
    mux5_rr_arbiter_if bus1 ();

    assign bus1.req = bus.req;

    mux5_rr_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mux5_rr_arbiter #(.HOLD_MAX(1), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic compare(input string name, input vec_t e);
        n_vec++;
        if (bus.grant !== e.grant || bus.sel !== e.sel || bus.busy !== e.busy ||
            bus.owner_timeout !== e.to) begin
            n_err++;
            $display("FAIL %s: got grant=%b sel=%0d busy=%b to=%b, want grant=%b sel=%0d busy=%b to=%b",
                     name, bus.grant, bus.sel, bus.busy, bus.owner_timeout,
                     e.grant, e.sel, e.busy, e.to);
        end
        if (!$onehot0(bus.grant) || bus.sel > 3'd4 || bus.busy !== (|bus.grant)) begin
            n_err++;
            $display("FAIL %s invariant: grant=%b sel=%0d busy=%b", name, bus.grant, bus.sel, bus.busy);
        end
    endtask

    // Drive one vector, queue its expectation, pop and compare after the edge.
    task automatic step(input string name, input vec_t v);
        vec_t e;
        bus.req = v.req;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            compare(name, e);
        end
    endtask

    task automatic do_reset();
        vec_t e;
        bus.req = 5'b00000;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        e = '{req: 5'b0, grant: 5'b0, sel: 3'd0, busy: 1'b0, to: 1'b0};
        compare("reset", e);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       e;
        logic [4:0] one;
        int         idx;
        one = 5'b00001;

        tbl_a[0] = '{req: 5'b00100, grant: 5'b00100, sel: 3'd2, busy: 1'b1, to: 1'b0};
        tbl_a[1] = '{req: 5'b00000, grant: 5'b00000, sel: 3'd2, busy: 1'b0, to: 1'b0};
        tbl_a[2] = '{req: 5'b00000, grant: 5'b00000, sel: 3'd2, busy: 1'b0, to: 1'b0};
        tbl_a[3] = '{req: 5'b10001, grant: 5'b10000, sel: 3'd4, busy: 1'b1, to: 1'b0};
        tbl_a[4] = '{req: 5'b00001, grant: 5'b00001, sel: 3'd0, busy: 1'b1, to: 1'b0};
        tbl_a[5] = '{req: 5'b00000, grant: 5'b00000, sel: 3'd0, busy: 1'b0, to: 1'b0};

        tbl_d[0] = '{req: 5'b01000, grant: 5'b01000, sel: 3'd3, busy: 1'b1, to: 1'b0};
        tbl_d[1] = '{req: 5'b11001, grant: 5'b01000, sel: 3'd3, busy: 1'b1, to: 1'b0};
        tbl_d[2] = '{req: 5'b10001, grant: 5'b10000, sel: 3'd4, busy: 1'b1, to: 1'b0};
        tbl_d[3] = '{req: 5'b00001, grant: 5'b00001, sel: 3'd0, busy: 1'b1, to: 1'b0};
        tbl_d[4] = '{req: 5'b00000, grant: 5'b00000, sel: 3'd0, busy: 1'b0, to: 1'b0};

        bus.req = 5'b00000;
        rst_n   = 1'b0;
        #2;

        do_reset();
        for (int i = 0; i < 6; i++) step($sformatf("basic[%0d]", i), tbl_a[i]);

        // All five requesting: HOLD_MAX=4 tenure each, HOLD_MAX=1 rotates every edge.
        do_reset();
        for (int k = 0; k < 24; k++) begin
            idx = (k / 4) % 5;
            e.req   = 5'b11111;
            e.grant = one << idx;
            e.sel   = 3'(idx);
            e.busy  = 1'b1;
            e.to    = (k > 0) && (k % 4 == 0);
            step($sformatf("fair[%0d]", k), e);
            n_vec++;
            if (bus1.grant !== (one << (k % 5)) || bus1.sel !== 3'(k % 5) ||
                bus1.owner_timeout !== (k > 0)) begin
                n_err++;
                $display("FAIL hold1[%0d]: got grant=%b sel=%0d to=%b, want sel=%0d to=%b",
                         k, bus1.grant, bus1.sel, bus1.owner_timeout, k % 5, k > 0);
            end
        end

        do_reset();
        for (int k = 0; k < 20; k++) begin
            e = '{req: 5'b00010, grant: 5'b00010, sel: 3'd1, busy: 1'b1, to: 1'b0};
            step($sformatf("alone[%0d]", k), e);
        end

        do_reset();
        for (int i = 0; i < 5; i++) step($sformatf("handoff[%0d]", i), tbl_d[i]);

        // Owner 2 drops its request exactly on the expiry edge.
        do_reset();
        e = '{req: 5'b00100, grant: 5'b00100, sel: 3'd2, busy: 1'b1, to: 1'b0};
        step("expire_rel[0]", e);
        for (int k = 1; k < 4; k++) begin
            e = '{req: 5'b00101, grant: 5'b00100, sel: 3'd2, busy: 1'b1, to: 1'b0};
            step($sformatf("expire_rel[%0d]", k), e);
        end
        e = '{req: 5'b00001, grant: 5'b00001, sel: 3'd0, busy: 1'b1, to: 1'b0};
        step("expire_rel[4]", e);

        // Asynchronous reset while requester 3 owns the mux.
        do_reset();
        e = '{req: 5'b01000, grant: 5'b01000, sel: 3'd3, busy: 1'b1, to: 1'b0};
        step("async_pre", e);
        rst_n = 1'b0;
        #2;
        e = '{req: 5'b01000, grant: 5'b00000, sel: 3'd0, busy: 1'b0, to: 1'b0};
        compare("async_rst", e);
        bus.req = 5'b11111;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e = '{req: 5'b11111, grant: 5'b00001, sel: 3'd0, busy: 1'b1, to: 1'b0};
        step("async_post", e);

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
